radarpim_reset_sequencer: RTL and testbench

Parametrised clock-domain reset sequencer for the RadarPIM system clock tree. It sits behind the Xilinx clock PLL wrapper and filters the PLL lock indication. After lock is stable it releases NUM_DOMAINS active-low domain resets one at a time with a programmable gap between them. It also re-asserts every domain reset on lock loss or on a software reset request, and counts lock-loss events.

---
 rtl/radarpim_reset_sequencer_if.sv | 39 +++
 rtl/radarpim_reset_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_radarpim_reset_sequencer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/radarpim_reset_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : radarpim_reset_sequencer_if
//  Description : Lock/request inputs and sequenced reset/status outputs of
//                the RadarPIM clock-domain reset sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface radarpim_reset_sequencer_if #(
    parameter int NUM_DOMAINS = 4,
    parameter int CNT_W       = 8
);
    logic                   pll_locked;
    logic                   soft_rst_req;
    logic [NUM_DOMAINS-1:0] domain_rstnn;
    logic                   seq_done;
    logic [CNT_W-1:0]       lock_lost_cnt;
    logic [2:0]             seq_state;

    // System side: drives lock and software request, observes resets.
    modport master (
        output pll_locked,
        output soft_rst_req,
        input  domain_rstnn,
        input  seq_done,
        input  lock_lost_cnt,
        input  seq_state
    );

    // Sequencer side.
    modport slave (
        input  pll_locked,
        input  soft_rst_req,
        output domain_rstnn,
        output seq_done,
        output lock_lost_cnt,
        output seq_state
    );
endinterface
`default_nettype wire

// File: rtl/radarpim_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : radarpim_reset_sequencer
//  Description : Filters the PLL lock, then releases NUM_DOMAINS active-low
//                domain resets one at a time with a fixed gap. Re-asserts all
//                domains on lock loss or software request and counts losses.
//  Revision    : 1.0 - initial release
// ============================================================================
module radarpim_reset_sequencer #(
    parameter int NUM_DOMAINS      = 4,
    parameter int LOCK_FILTER      = 1024,
    parameter int STAGGER          = 16,
    parameter int SOFT_HOLD_CYCLES = 64,
    parameter int CNT_W            = 8
) (
    input  wire logic                        external_clk,
    input  wire logic                        external_rst,
    radarpim_reset_sequencer_if.slave        bus
);

    // Counter sizing: each counter holds 0..max, max being a compare target.
    localparam int c_REL_MAX  = (NUM_DOMAINS - 1) * STAGGER;
    localparam int c_REL_W    = (c_REL_MAX > 0) ? $clog2(c_REL_MAX + 1) : 1;
    localparam int c_FILT_W   = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
    localparam int c_HOLD_W   = (SOFT_HOLD_CYCLES > 1) ? $clog2(SOFT_HOLD_CYCLES) : 1;

    localparam logic [c_REL_W-1:0]  c_REL_LAST  = c_REL_W'(c_REL_MAX);
    localparam logic [c_FILT_W-1:0] c_FILT_LAST = c_FILT_W'(LOCK_FILTER - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(SOFT_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]    c_LOST_MAX  = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_RESET_HOLD = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_FILTER     = 3'd2,
        ST_RELEASE    = 3'd3,
        ST_RUN        = 3'd4,
        ST_SOFT_HOLD  = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [1:0]             r_sync;
    logic [c_FILT_W-1:0]    r_filt_cnt;
    logic [c_FILT_W-1:0]    w_filt_cnt_nxt;
    logic [c_REL_W-1:0]     r_rel_cnt;
    logic [c_REL_W-1:0]     w_rel_cnt_nxt;
    logic [c_HOLD_W-1:0]    r_hold_cnt;
    logic [c_HOLD_W-1:0]    w_hold_cnt_nxt;
    logic [NUM_DOMAINS-1:0] r_domain;
    logic [NUM_DOMAINS-1:0] w_domain_nxt;
    logic                   r_seq_done;
    logic                   w_seq_done_nxt;
    logic [CNT_W-1:0]       r_lost_cnt;
    logic [CNT_W-1:0]       w_lost_cnt_nxt;
    logic [NUM_DOMAINS-1:0] w_release_mask;
    logic                   w_lock_s;
    logic                   w_lock_loss;

    assign w_lock_s = r_sync[1];

    // Domain i becomes eligible once rel_cnt reaches i*STAGGER.
    for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_release_mask
        if (i == 0) begin : g_first
            assign w_release_mask[i] = 1'b1;
        end else begin : g_rest
            localparam logic [c_REL_W-1:0] c_THRESH = c_REL_W'(i * STAGGER);
            assign w_release_mask[i] = (r_rel_cnt >= c_THRESH);
        end
    end

    // Lock is only "lost" once the sequencer has left the filter path.
    assign w_lock_loss = !w_lock_s &&
                         ((r_state == ST_RELEASE) || (r_state == ST_RUN) ||
                          (r_state == ST_SOFT_HOLD));

    // Two-flop synchroniser for the asynchronous PLL lock.
    always_ff @(posedge external_clk) begin
        if (external_rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], bus.pll_locked};
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge external_clk) begin
        if (external_rst) begin
            r_state    <= ST_RESET_HOLD;
            r_filt_cnt <= '0;
            r_rel_cnt  <= '0;
            r_hold_cnt <= '0;
            r_domain   <= '0;
            r_seq_done <= 1'b0;
            r_lost_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_filt_cnt <= w_filt_cnt_nxt;
            r_rel_cnt  <= w_rel_cnt_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_domain   <= w_domain_nxt;
            r_seq_done <= w_seq_done_nxt;
            r_lost_cnt <= w_lost_cnt_nxt;
        end
    end

    // Next-state logic; lock loss takes priority over every other event.
    always_comb begin
        w_state_nxt    = r_state;
        w_filt_cnt_nxt = r_filt_cnt;
        w_rel_cnt_nxt  = r_rel_cnt;
        w_hold_cnt_nxt = r_hold_cnt;
        w_domain_nxt   = r_domain;
        w_seq_done_nxt = r_seq_done;
        w_lost_cnt_nxt = r_lost_cnt;

        if (w_lock_loss) begin
            w_state_nxt    = ST_WAIT_LOCK;
            w_domain_nxt   = '0;
            w_seq_done_nxt = 1'b0;
            if (r_lost_cnt != c_LOST_MAX) begin
                w_lost_cnt_nxt = r_lost_cnt + CNT_W'(1);
            end
        end else begin
            case (r_state)
                ST_RESET_HOLD: begin
                    w_state_nxt = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (w_lock_s) begin
                        w_state_nxt    = ST_FILTER;
                        w_filt_cnt_nxt = '0;
                    end
                end
                ST_FILTER: begin
                    if (!w_lock_s) begin
                        w_state_nxt = ST_WAIT_LOCK;
                    end else if (r_filt_cnt == c_FILT_LAST) begin
                        w_state_nxt   = ST_RELEASE;
                        w_rel_cnt_nxt = '0;
                    end else begin
                        w_filt_cnt_nxt = r_filt_cnt + c_FILT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    w_domain_nxt = r_domain | w_release_mask;
                    if (r_rel_cnt == c_REL_LAST) begin
                        w_state_nxt    = ST_RUN;
                        w_seq_done_nxt = 1'b1;
                    end else begin
                        w_rel_cnt_nxt = r_rel_cnt + c_REL_W'(1);
                    end
                end
                ST_RUN: begin
                    if (bus.soft_rst_req) begin
                        w_state_nxt    = ST_SOFT_HOLD;
                        w_hold_cnt_nxt = '0;
                        w_domain_nxt   = '0;
                        w_seq_done_nxt = 1'b0;
                    end
                end
                ST_SOFT_HOLD: begin
                    // Lock is known good here, so skip the filter and re-release.
                    if (r_hold_cnt == c_HOLD_LAST) begin
                        w_state_nxt   = ST_RELEASE;
                        w_rel_cnt_nxt = '0;
                    end else begin
                        w_hold_cnt_nxt = r_hold_cnt + c_HOLD_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_RESET_HOLD;
                end
            endcase
        end
    end

    assign bus.domain_rstnn  = r_domain;
    assign bus.seq_done      = r_seq_done;
    assign bus.lock_lost_cnt = r_lost_cnt;
    assign bus.seq_state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_radarpim_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_radarpim_reset_sequencer
//  Description : Directed self-checking bench for radarpim_reset_sequencer
//                (NUM_DOMAINS=4, LOCK_FILTER=8, STAGGER=4, SOFT_HOLD=6, CNT_W=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_radarpim_reset_sequencer;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    radarpim_reset_sequencer_if #(.NUM_DOMAINS(4), .CNT_W(2)) bus ();

    radarpim_reset_sequencer #(
        .NUM_DOMAINS      (4),
        .LOCK_FILTER      (8),
        .STAGGER          (4),
        .SOFT_HOLD_CYCLES (6),
        .CNT_W            (2)
    ) u_dut (
        .external_clk (clk),
        .external_rst (rst),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] dom, input logic done,
                              input logic [2:0] st, input logic [1:0] lost);
        check({tag, "/dom"},   32'(bus.domain_rstnn),  32'(dom));
        check({tag, "/done"},  32'(bus.seq_done),      32'(done));
        check({tag, "/state"}, 32'(bus.seq_state),     32'(st));
        check({tag, "/lost"},  32'(bus.lock_lost_cnt), 32'(lost));
    endtask

    // Advance n rising edges; leave time just after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // From WAIT_LOCK with the synchroniser low: raise lock, first edge is e0.
    task automatic cold_start(input string tag, input logic [1:0] lost);
        bus.pll_locked = 1'b1;
        tick(1);                                      // e0
        tick(1);                                      // e0+1
        check({tag, "/e1"}, 32'(bus.seq_state), 32'd1);
        tick(1);                                      // e0+2
        check({tag, "/e2"}, 32'(bus.seq_state), 32'd2);
        tick(8);                                      // e0+10
        check_outs({tag, "/e10"}, 4'b0000, 1'b0, 3'd3, lost);
        tick(1);                                      // e0+11
        check({tag, "/e11"}, 32'(bus.domain_rstnn), 32'h1);
        tick(4);                                      // e0+15
        check({tag, "/e15"}, 32'(bus.domain_rstnn), 32'h3);
        tick(4);                                      // e0+19
        check({tag, "/e19"}, 32'(bus.domain_rstnn), 32'h7);
        tick(3);                                      // e0+22
        check_outs({tag, "/e22"}, 4'b0111, 1'b0, 3'd3, lost);
        tick(1);                                      // e0+23
        check_outs({tag, "/e23"}, 4'b1111, 1'b1, 3'd4, lost);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.pll_locked   = 1'b0;
        bus.soft_rst_req = 1'b0;

        // Reset state
        tick(3);
        check_outs("reset", 4'b0000, 1'b0, 3'd0, 2'd0);
        rst = 1'b0;
        tick(1);
        check("rst_exit", 32'(bus.seq_state), 32'd1);
        tick(2);
        check("wait_idle", 32'(bus.seq_state), 32'd1);

        // Cold start
        cold_start("cold", 2'd0);

        // Soft request in RUN, then a request during RELEASE is ignored
        bus.soft_rst_req = 1'b1;
        tick(1);                                      // g
        bus.soft_rst_req = 1'b0;
        check_outs("soft_g", 4'b0000, 1'b0, 3'd5, 2'd0);
        tick(5);                                      // g+5
        check("soft_g5", 32'(bus.seq_state), 32'd5);
        tick(1);                                      // g+6
        check_outs("soft_g6", 4'b0000, 1'b0, 3'd3, 2'd0);
        tick(1);                                      // g+7
        check("soft_g7", 32'(bus.domain_rstnn), 32'h1);
        bus.soft_rst_req = 1'b1;
        tick(1);                                      // g+8, in RELEASE
        bus.soft_rst_req = 1'b0;
        check_outs("soft_rel", 4'b0001, 1'b0, 3'd3, 2'd0);
        tick(10);                                     // g+18
        check("soft_g18", 32'(bus.domain_rstnn), 32'h7);
        tick(1);                                      // g+19
        check_outs("soft_g19", 4'b1111, 1'b1, 3'd4, 2'd0);

        // Lock loss in RUN four times, counter saturates at 3
        for (int k = 1; k <= 4; k++) begin
            bus.pll_locked = 1'b0;
            tick(1);                                  // f0
            tick(1);                                  // f0+1
            check_outs($sformatf("loss%0d_f1", k), 4'b1111, 1'b1, 3'd4,
                       2'((k - 1 > 3) ? 3 : k - 1));
            tick(1);                                  // f0+2
            check_outs($sformatf("loss%0d_f2", k), 4'b0000, 1'b0, 3'd1,
                       2'((k > 3) ? 3 : k));
            cold_start($sformatf("recov%0d", k), 2'((k > 3) ? 3 : k));
        end

        // external_rst during RELEASE with 0011
        bus.pll_locked = 1'b0;
        tick(3);                                      // now in WAIT_LOCK, s low
        check("pre_rst", 32'(bus.seq_state), 32'd1);
        bus.pll_locked = 1'b1;
        tick(16);                                     // e0+15
        check_outs("rel_0011", 4'b0011, 1'b0, 3'd3, 2'd3);
        rst = 1'b1;
        tick(1);
        check_outs("mid_rst", 4'b0000, 1'b0, 3'd0, 2'd0);
        rst = 1'b0;
        cold_start("after_rst", 2'd0);

        // Lock loss and soft request on the same edge
        bus.pll_locked = 1'b0;
        tick(1);                                      // f0
        tick(1);                                      // f0+1
        bus.soft_rst_req = 1'b1;
        tick(1);                                      // f0+2: s first reads 0
        bus.soft_rst_req = 1'b0;
        check_outs("simul", 4'b0000, 1'b0, 3'd1, 2'd1);

        // Filter glitch after a clean reset
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        bus.pll_locked = 1'b1;
        tick(5);                                      // edges e0..e0+4 see 1
        check("glitch_filter", 32'(bus.seq_state), 32'd2);
        bus.pll_locked = 1'b0;
        tick(1);                                      // e0+5 sees 0
        bus.pll_locked = 1'b1;
        tick(1);                                      // r (final rise), e0+6
        check("glitch_r", 32'(bus.seq_state), 32'd2);
        tick(1);                                      // r+1
        check_outs("glitch_r1", 4'b0000, 1'b0, 3'd1, 2'd0);
        tick(1);                                      // r+2
        check("glitch_r2", 32'(bus.seq_state), 32'd2);
        tick(8);                                      // r+10
        check_outs("glitch_r10", 4'b0000, 1'b0, 3'd3, 2'd0);
        tick(1);                                      // r+11
        check_outs("glitch_r11", 4'b0001, 1'b0, 3'd3, 2'd0);
        tick(12);                                     // r+23
        check_outs("glitch_r23", 4'b1111, 1'b1, 3'd4, 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
